instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the DOF-stage decoder: packs opcode/field requests into 32-bit instruction words and streams them into instruction memory.
// - Sits between the testbench/boot source and the IMEM write port; fills a block of N words from a base address.
// - Illegal opcodes are replaced by NOP and flagged, so the decoder never sees an undefined word.
// PARAMETERS
// - ADDR_W   8    IMEM word-address width
// - CNT_W    9    length counter width; N up to 2^CNT_W-1
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       synchronous, active-low reset
// - start       in   1       one-cycle pulse: begin load; sampled only in IDLE
// - base_addr   in   ADDR_W  first IMEM address, latched on start
// - length      in   CNT_W   words to load, latched on start
// - in_valid    in   1       field bundle valid
// - in_ready    out  1       encoder accepts bundle this cycle
// - in_op       in   7       opcode (OP_* constants)
// - in_dr       in   5       destination register
// - in_sa       in   5       source A
// - in_sb       in   5       source B / shift amount
// - in_imm      in   15      immediate / branch offset
// - imem_we     out  1       IMEM write strobe
// - imem_addr   out  ADDR_W  IMEM write address
// - imem_wdata  out  32      encoded instruction
// - busy        out  1       high in LOAD and DRAIN
// - done        out  1       one-cycle pulse when the last word is written
// - err_illegal out  1       sticky until next start: an illegal opcode was substituted
// - wrapped     out  1       sticky until next start: address wrapped past 2^ADDR_W-1
// - checksum    out  32      see CONFIGURATION
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; counters and latched base cleared.
// - FSM states: IDLE -> (start & length!=0) -> LOAD -> (last word accepted) -> DRAIN -> IDLE.
//   start with length==0: done pulses the next cycle, FSM stays in IDLE.
//   start while not IDLE is ignored.
// - in_ready = (state==LOAD) & (remaining!=0). A transfer occurs when in_valid & in_ready.
// - Latency: a bundle accepted in cycle t gives imem_we=1 with registered addr/data in cycle t+1.
//   Back-to-back accepts give one write per cycle.
// - Word format: [31:25]=op, [24:20]=DR, [19:15]=SA, [14:0]=low field. Unused fields are forced to 0:
//   - R-class (ADD SUB SLT AND OR XOR ST): low={SB,10'b0}
//   - I-class (ADI SBI ANI ORI XRI AIU SIU LD): low=imm
//   - MOV NOT: low=0
//   - LSL LSR: low={10'b0,SB}
//   - JMR: DR=0, low=0
//   - BZ BNZ: DR=0, low=imm
//   - JMP: DR=SA=0, low=imm
//   - JML: SA=0, low=imm
//   - NOP: all fields 0
// - Illegal opcode: write {OP_NOP,25'b0} to the same slot and set err_illegal. The slot is consumed.
// - imem_addr starts at base_addr and increments modulo 2^ADDR_W.
//   On the transition from all-ones to 0, set wrapped and continue writing.
// - DRAIN: one cycle for the final write; done=1 in that cycle, then return to IDLE.
// - Reset mid-load: load is abandoned next edge, no further writes, no done.
// CONFIGURATION
// - ENCODER_CHECKSUM_EN defined:
//   - checksum = running XOR of every imem_wdata written since start, cleared on start.
//   - Valid in the done cycle and held until the next start.
// - ENCODER_CHECKSUM_EN undefined: checksum tied to 32'h0 and no register is built.
// STRUCTURE
// - Shared definitions header: OP_* opcodes, field bit positions/widths, INSTR_W=32.
//   Add OPCLASS_* class codes there too.
// - Sub-module instr_field_packer: combinational op+fields -> {word, illegal}. The top holds the FSM, counters, and output registers.
// TESTING
// - start base=8'h10 len=1; ADD DR=1 SA=2 SB=3 -> one cycle later: we=1, addr=8'h10, data={OP_ADD,5'd1,5'd2,5'd3,10'd0}; done pulses.
// - ADI DR=4 SA=4 imm=15'h7FFF -> data={OP_ADI,5'd4,5'd4,15'h7FFF}.
//   JMP with DR=7 SA=9 imm=5 -> DR and SA encoded as 0.
// - Opcode 7'h7F (illegal), len=1 -> data={OP_NOP,25'b0}; err_illegal=1 until the next start.
// - base=8'hFE len=3, in_valid held high -> writes at FE, FF, 00 on consecutive cycles; wrapped=1; done on the 3rd write.
// - len=4 with in_valid toggling 1,0,1,0 -> exactly 4 writes, no gaps beyond the valid gaps; in_ready=0 after the 4th accept.
// - rst_n=0 after 2 of 5 words -> no further imem_we, busy=0, done never pulses.
//   With ENCODER_CHECKSUM_EN: after a 2-word load, checksum equals the XOR of both words.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - opcodes, field layout and opcode classes for the instruction encoder
package instr_encoder_loader_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_W    = 7;
  localparam int REG_W   = 5;
  localparam int LOW_W   = 15;
  localparam int OP_LSB  = 25;
  localparam int DR_LSB  = 20;
  localparam int SA_LSB  = 15;

  localparam logic [OP_W-1:0] OP_NOP = 7'h00;
  localparam logic [OP_W-1:0] OP_ADD = 7'h01;
  localparam logic [OP_W-1:0] OP_SUB = 7'h02;
  localparam logic [OP_W-1:0] OP_SLT = 7'h03;
  localparam logic [OP_W-1:0] OP_AND = 7'h04;
  localparam logic [OP_W-1:0] OP_OR  = 7'h05;
  localparam logic [OP_W-1:0] OP_XOR = 7'h06;
  localparam logic [OP_W-1:0] OP_ST  = 7'h07;
  localparam logic [OP_W-1:0] OP_ADI = 7'h08;
  localparam logic [OP_W-1:0] OP_SBI = 7'h09;
  localparam logic [OP_W-1:0] OP_ANI = 7'h0A;
  localparam logic [OP_W-1:0] OP_ORI = 7'h0B;
  localparam logic [OP_W-1:0] OP_XRI = 7'h0C;
  localparam logic [OP_W-1:0] OP_AIU = 7'h0D;
  localparam logic [OP_W-1:0] OP_SIU = 7'h0E;
  localparam logic [OP_W-1:0] OP_LD  = 7'h0F;
  localparam logic [OP_W-1:0] OP_MOV = 7'h10;
  localparam logic [OP_W-1:0] OP_NOT = 7'h11;
  localparam logic [OP_W-1:0] OP_LSL = 7'h12;
  localparam logic [OP_W-1:0] OP_LSR = 7'h13;
  localparam logic [OP_W-1:0] OP_JMR = 7'h14;
  localparam logic [OP_W-1:0] OP_BZ  = 7'h15;
  localparam logic [OP_W-1:0] OP_BNZ = 7'h16;
  localparam logic [OP_W-1:0] OP_JMP = 7'h17;
  localparam logic [OP_W-1:0] OP_JML = 7'h18;

  typedef enum logic [3:0] {
    OPCLASS_NOP,
    OPCLASS_R,
    OPCLASS_I,
    OPCLASS_UN,
    OPCLASS_SH,
    OPCLASS_JR,
    OPCLASS_BR,
    OPCLASS_JMP,
    OPCLASS_JML,
    OPCLASS_ILL
  } opclass_e;

  function automatic opclass_e op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_NOP:                                              return OPCLASS_NOP;
      OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_ST: return OPCLASS_R;
      OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_AIU,
      OP_SIU, OP_LD:                                       return OPCLASS_I;
      OP_MOV, OP_NOT:                                      return OPCLASS_UN;
      OP_LSL, OP_LSR:                                      return OPCLASS_SH;
      OP_JMR:                                              return OPCLASS_JR;
      OP_BZ, OP_BNZ:                                       return OPCLASS_BR;
      OP_JMP:                                              return OPCLASS_JMP;
      OP_JML:                                              return OPCLASS_JML;
      default:                                             return OPCLASS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational op+fields to 32-bit instruction word, illegal ops become NOP
import instr_encoder_loader_pkg::*;

module instr_field_packer (
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   dr,
  input  logic [REG_W-1:0]   sa,
  input  logic [REG_W-1:0]   sb,
  input  logic [LOW_W-1:0]   imm,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  logic [OP_W-1:0]  op_f;
  logic [REG_W-1:0] dr_f;
  logic [REG_W-1:0] sa_f;
  logic [LOW_W-1:0] low_f;

  // Fields an opcode class does not use are zeroed so every word decodes canonically.
  always_comb begin
    op_f    = op;
    dr_f    = dr;
    sa_f    = sa;
    low_f   = '0;
    illegal = 1'b0;
    case (op_class(op))
      OPCLASS_R:   low_f = {sb, 10'b0};
      OPCLASS_I:   low_f = imm;
      OPCLASS_UN:  low_f = '0;
      OPCLASS_SH:  low_f = {10'b0, sb};
      OPCLASS_JR:  dr_f  = '0;
      OPCLASS_BR: begin
        dr_f  = '0;
        low_f = imm;
      end
      OPCLASS_JMP: begin
        dr_f  = '0;
        sa_f  = '0;
        low_f = imm;
      end
      OPCLASS_JML: begin
        sa_f  = '0;
        low_f = imm;
      end
      OPCLASS_NOP: begin
        dr_f = '0;
        sa_f = '0;
      end
      default: begin
        op_f    = OP_NOP;
        dr_f    = '0;
        sa_f    = '0;
        illegal = 1'b1;
      end
    endcase

    word = '0;
    word[OP_LSB +: OP_W]  = op_f;
    word[DR_LSB +: REG_W] = dr_f;
    word[SA_LSB +: REG_W] = sa_f;
    word[0 +: LOW_W]      = low_f;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs field bundles into instruction words and streams a block into IMEM
// Optional running XOR checksum of written words: ENCODER_CHECKSUM_EN.
import instr_encoder_loader_pkg::*;

module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   length,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [REG_W-1:0]   in_dr,
  input  logic [REG_W-1:0]   in_sa,
  input  logic [REG_W-1:0]   in_sb,
  input  logic [LOW_W-1:0]   in_imm,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               wrapped,
  output logic [INSTR_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_e;

  state_e              state;
  state_e              state_nxt;
  logic [CNT_W-1:0]    remaining;
  logic [ADDR_W-1:0]   next_addr;
  logic                first_word;
  logic                load_start;
  logic                accept;
  logic                last_accept;
  logic [INSTR_W-1:0]  packed_word;
  logic                packed_illegal;

  instr_field_packer u_packer (
    .op      (in_op),
    .dr      (in_dr),
    .sa      (in_sa),
    .sb      (in_sb),
    .imm     (in_imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  assign load_start  = (state == S_IDLE) && start;
  assign in_ready    = (state == S_LOAD) && (remaining != '0);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (remaining == CNT_W'(1));
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && (length != '0)) state_nxt = S_LOAD;
      S_LOAD:  if (last_accept) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A zero-length start never leaves IDLE but still reports completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      wrapped     <= 1'b0;
      remaining   <= '0;
      next_addr   <= '0;
      first_word  <= 1'b0;
    end else begin
      imem_we <= accept;
      done    <= last_accept || (load_start && (length == '0));
      if (load_start) begin
        next_addr   <= base_addr;
        remaining   <= length;
        first_word  <= 1'b1;
        err_illegal <= 1'b0;
        wrapped     <= 1'b0;
      end else if (accept) begin
        imem_addr  <= next_addr;
        imem_wdata <= packed_word;
        next_addr  <= next_addr + 1'b1;
        remaining  <= remaining - 1'b1;
        first_word <= 1'b0;
        if (packed_illegal) err_illegal <= 1'b1;
        // Wrap is flagged only when a write actually lands on 0 after FF, not when base is 0.
        if ((next_addr == '0) && !first_word) wrapped <= 1'b1;
      end
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)          checksum <= '0;
    else if (load_start) checksum <= '0;
    else if (accept)     checksum <= checksum ^ packed_word;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

  localparam logic [6:0] T_NOP = 7'h00, T_ADD = 7'h01, T_SUB = 7'h02, T_XOR = 7'h06;
  localparam logic [6:0] T_ADI = 7'h08, T_LSL = 7'h12, T_JMR = 7'h14, T_BZ = 7'h15;
  localparam logic [6:0] T_JMP = 7'h17, T_JML = 7'h18, T_BAD = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [4:0]  in_dr, in_sa, in_sb;
  logic [14:0] in_imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err_illegal, wrapped;
  logic [31:0] checksum;

  int errors = 0;
  int checks = 0;

  logic [31:0] w1, w2, csum_exp;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dr(in_dr), .in_sa(in_sa),
    .in_sb(in_sb), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_illegal(err_illegal),
    .wrapped(wrapped), .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [6:0] op, input logic [4:0] dr, input logic [4:0] sa,
                     input logic [4:0] sb, input logic [14:0] imm);
    in_valid = 1'b1;
    in_op = op; in_dr = dr; in_sa = sa; in_sb = sb; in_imm = imm;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [8:0] len);
    start = 1'b1; base_addr = base; length = len;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                              input logic dn);
    check({tag, "_we"},   32'(imem_we),   32'd1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(a));
    check({tag, "_data"}, imem_wdata,     d);
    check({tag, "_done"}, 32'(done),      32'(dn));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    in_valid = 1'b0; in_op = '0; in_dr = '0; in_sa = '0; in_sb = '0; in_imm = '0;
    tick(); tick();
    check("rst_we",     32'(imem_we),     32'd0);
    check("rst_addr",   32'(imem_addr),   32'd0);
    check("rst_data",   imem_wdata,       32'd0);
    check("rst_busy",   32'(busy),        32'd0);
    check("rst_done",   32'(done),        32'd0);
    check("rst_err",    32'(err_illegal), 32'd0);
    check("rst_wrap",   32'(wrapped),     32'd0);
    check("rst_ready",  32'(in_ready),    32'd0);
    check("rst_csum",   checksum,         32'd0);
    rst_n = 1'b1;
    tick();

    // single ADD word
    start_load(8'h10, 9'd1);
    check("add_ready", 32'(in_ready), 32'd1);
    check("add_busy",  32'(busy),     32'd1);
    put(T_ADD, 5'd1, 5'd2, 5'd3, 15'h1234);
    tick();
    in_valid = 1'b0;
    expect_write("add", 8'h10, {7'h01, 5'd1, 5'd2, 5'd3, 10'd0}, 1'b1);
    check("add_ready_drain", 32'(in_ready), 32'd0);
    tick();
    check("add_done_clr", 32'(done),    32'd0);
    check("add_we_clr",   32'(imem_we), 32'd0);
    check("add_idle",     32'(busy),    32'd0);

    // back-to-back field masking: ADI, JMP, LSL
    start_load(8'h20, 9'd3);
    put(T_ADI, 5'd4, 5'd4, 5'd31, 15'h7FFF);
    tick();
    put(T_JMP, 5'd7, 5'd9, 5'd3, 15'd5);
    expect_write("adi", 8'h20, {7'h08, 5'd4, 5'd4, 15'h7FFF}, 1'b0);
    tick();
    put(T_LSL, 5'd2, 5'd3, 5'd17, 15'h5555);
    expect_write("jmp", 8'h21, {7'h17, 10'd0, 15'd5}, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_write("lsl", 8'h22, {7'h12, 5'd2, 5'd3, 10'd0, 5'd17}, 1'b1);
    tick();

    // JMR, BZ, JML
    start_load(8'h28, 9'd3);
    put(T_JMR, 5'd6, 5'd8, 5'd9, 15'd77);
    tick();
    put(T_BZ, 5'd5, 5'd1, 5'd2, 15'h100);
    expect_write("jmr", 8'h28, {7'h14, 5'd0, 5'd8, 15'd0}, 1'b0);
    tick();
    put(T_JML, 5'd31, 5'd2, 5'd4, 15'd3);
    expect_write("bz", 8'h29, {7'h15, 5'd0, 5'd1, 15'h100}, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_write("jml", 8'h2A, {7'h18, 5'd31, 5'd0, 15'd3}, 1'b1);
    tick();

    // illegal opcode becomes NOP, err sticky until next start
    start_load(8'h30, 9'd1);
    put(T_BAD, 5'd1, 5'd2, 5'd3, 15'd4);
    tick();
    in_valid = 1'b0;
    expect_write("ill", 8'h30, 32'h0, 1'b1);
    check("ill_err", 32'(err_illegal), 32'd1);
    tick();
    check("ill_err_sticky", 32'(err_illegal), 32'd1);
    start_load(8'h31, 9'd1);
    check("ill_err_clr", 32'(err_illegal), 32'd0);
    put(T_NOP, 5'd3, 5'd3, 5'd3, 15'd3);
    tick();
    in_valid = 1'b0;
    expect_write("nop", 8'h31, 32'h0, 1'b1);
    check("nop_err", 32'(err_illegal), 32'd0);
    tick();

    // address wrap FE, FF, 00
    start_load(8'hFE, 9'd3);
    put(T_ADD, 5'd1, 5'd1, 5'd1, 15'd0);
    tick();
    expect_write("wrap0", 8'hFE, {7'h01, 5'd1, 5'd1, 5'd1, 10'd0}, 1'b0);
    check("wrap0_flag", 32'(wrapped), 32'd0);
    tick();
    expect_write("wrap1", 8'hFF, {7'h01, 5'd1, 5'd1, 5'd1, 10'd0}, 1'b0);
    check("wrap1_flag", 32'(wrapped), 32'd0);
    tick();
    in_valid = 1'b0;
    expect_write("wrap2", 8'h00, {7'h01, 5'd1, 5'd1, 5'd1, 10'd0}, 1'b1);
    check("wrap2_flag", 32'(wrapped), 32'd1);
    tick();
    check("wrap_sticky", 32'(wrapped), 32'd1);
    check("wrap_idle",   32'(busy),    32'd0);

    // toggling valid, with an ignored start mid-load
    start_load(8'h40, 9'd4);
    check("tog_wrap_clr", 32'(wrapped), 32'd0);
    put(T_XOR, 5'd1, 5'd2, 5'd3, 15'd0);
    for (int i = 0; i < 8; i++) begin
      in_valid = ~i[0];
      if (i == 3) begin
        start = 1'b1; base_addr = 8'h99; length = 9'd1;
      end
      tick();
      start = 1'b0;
      if (i[0] == 1'b0) begin
        expect_write($sformatf("tog%0d", i), 8'(8'h40 + i / 2),
                     {7'h06, 5'd1, 5'd2, 5'd3, 10'd0}, (i == 6));
        if (i == 6) check("tog_ready_after", 32'(in_ready), 32'd0);
      end else begin
        check($sformatf("tog%0d_we", i), 32'(imem_we), 32'd0);
      end
    end
    in_valid = 1'b1;
    tick();
    check("tog_no_extra", 32'(imem_we), 32'd0);
    in_valid = 1'b0;

    // zero length
    start_load(8'h50, 9'd0);
    check("len0_done", 32'(done),    32'd1);
    check("len0_busy", 32'(busy),    32'd0);
    check("len0_we",   32'(imem_we), 32'd0);
    tick();
    check("len0_done_clr", 32'(done), 32'd0);

    // reset mid-load after two of five words
    start_load(8'h60, 9'd5);
    put(T_ADD, 5'd1, 5'd2, 5'd3, 15'd0);
    tick();
    put(T_SUB, 5'd4, 5'd5, 5'd6, 15'd0);
    tick();
    expect_write("rml1", 8'h61, {7'h02, 5'd4, 5'd5, 5'd6, 10'd0}, 1'b0);
    rst_n = 1'b0;
    tick();
    check("rml_we",   32'(imem_we),  32'd0);
    check("rml_busy", 32'(busy),     32'd0);
    check("rml_done", 32'(done),     32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rml_post%0d_we", k),   32'(imem_we), 32'd0);
      check($sformatf("rml_post%0d_done", k), 32'(done),    32'd0);
    end
    in_valid = 1'b0;

    // checksum over a two-word load
    w1 = {7'h01, 5'd1, 5'd2, 5'd3, 10'd0};
    w2 = {7'h02, 5'd4, 5'd5, 5'd6, 10'd0};
`ifdef ENCODER_CHECKSUM_EN
    csum_exp = w1 ^ w2;
`else
    csum_exp = 32'h0;
`endif
    start_load(8'h70, 9'd2);
    put(T_ADD, 5'd1, 5'd2, 5'd3, 15'd0);
    tick();
    put(T_SUB, 5'd4, 5'd5, 5'd6, 15'd0);
    tick();
    in_valid = 1'b0;
    expect_write("cs", 8'h71, w2, 1'b1);
    check("cs_value", checksum, csum_exp);
    tick();
    check("cs_hold", checksum, csum_exp);
    start_load(8'h72, 9'd1);
    check("cs_clr", checksum, 32'h0);
    put(T_NOP, 5'd0, 5'd0, 5'd0, 15'd0);
    tick();
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
